hdbn_encoder: RTL and testbench

- Parametrised HDBn line encoder; successor to the fixed HDB3 encoder.
- Converts a strobed NRZ bit stream into 3-level line symbols using an N-zero substitution code (N=3 gives HDB3).
- Adds a runtime AMI bypass mode and an input/output valid strobe.
- Sits between the bit source (pulse generator / framer) and the line driver or decoder under test.

---
 rtl/hdbn_pkg.sv | 18 +
 rtl/hdbn_polarity.sv | 61 ++++++
 rtl/hdbn_encoder.sv | 107 ++++++++++
 tb/tb_hdbn_encoder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdbn_pkg.sv
// Shared types and constants for the HDBn line encoder.
//   sym_e     : symbol type held in the look-ahead window. SYM_ZERO is
//               deliberately encoded as 0 so a cleared window reads as zeros.
//   CODE_*    : 2-bit line symbol encoding driven on o_code.
package hdbn_pkg;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'd0,
    SYM_ONE  = 2'd1,
    SYM_B    = 2'd2,
    SYM_V    = 2'd3
  } sym_e;

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b10;

endpackage

// File: rtl/hdbn_polarity.sv
// Polarity stage of the HDBn encoder.
// Converts the symbol type leaving the look-ahead window into a signed line
// symbol, tracking the polarity of the last transmitted pulse.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_sym        : symbol type leaving the window
//   i_stb        : i_sym is valid this cycle
//   o_code       : registered line symbol (holds between strobes)
//   o_valid      : one-cycle pulse per new symbol
module hdbn_polarity
  import hdbn_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  sym_e       i_sym,
  input  logic       i_stb,
  output logic [1:0] o_code,
  output logic       o_valid
);

  logic [1:0] code_q, code_d;
  logic       valid_q, valid_d;
  // 1 = last pulse was +1, 0 = last pulse was -1.
  logic       last_pos_q, last_pos_d;

  always_comb begin
    code_d     = code_q;
    valid_d    = i_stb;
    last_pos_d = last_pos_q;
    if (i_stb) begin
      case (i_sym)
        SYM_ONE, SYM_B: begin
          // Marks and B pulses alternate with the previous pulse.
          code_d     = last_pos_q ? CODE_NEG : CODE_POS;
          last_pos_d = ~last_pos_q;
        end
        SYM_V: begin
          // Violation repeats the previous polarity and does not move it.
          code_d = last_pos_q ? CODE_POS : CODE_NEG;
        end
        default: code_d = CODE_ZERO;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      code_q     <= CODE_ZERO;
      valid_q    <= 1'b0;
      last_pos_q <= 1'b0;
    end else begin
      code_q     <= code_d;
      valid_q    <= valid_d;
      last_pos_q <= last_pos_d;
    end
  end

  assign o_code  = code_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/hdbn_encoder.sv
// HDBn line encoder (N=3 gives HDB3) with runtime AMI bypass.
// Strobed NRZ bits are classified into symbol types and pushed through an
// (N+1)-deep look-ahead window so that the B pulse of a B0..0V substitution
// can be placed retroactively on the first zero of the run. The entry leaving
// the window is turned into a line symbol by hdbn_polarity.
// Legal range of N is 2..7.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_data       : NRZ bit, sampled when i_valid=1
//   i_valid      : input strobe, one bit per high cycle
//   i_ami        : 1 = plain AMI, 0 = HDBn substitution (sampled per bit)
//   o_code       : line symbol 00=0, 01=+1, 10=-1
//   o_valid      : one-cycle pulse per output symbol
module hdbn_encoder
  import hdbn_pkg::*;
#(
  parameter int N = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_data,
  input  logic       i_valid,
  input  logic       i_ami,
  output logic [1:0] o_code,
  output logic       o_valid
);

  localparam int DEPTH = N + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] RUN_MAX   = CW'(N);
  localparam logic [CW-1:0] FILL_FULL = CW'(DEPTH);

  // Index 0 is the newest entry, DEPTH-1 the oldest.
  logic [DEPTH-1:0][1:0] win_q, win_d;
  logic [CW-1:0]         zcnt_q, zcnt_d;
  logic [CW-1:0]         fill_q, fill_d;
  // Parity of marks since the last V: 0 = even.
  logic                  par_q, par_d;

  logic                  out_stb;
  sym_e                  exit_sym;

  always_comb begin
    win_d  = win_q;
    zcnt_d = zcnt_q;
    fill_d = fill_q;
    par_d  = par_q;
    if (i_valid) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        win_d[i] = win_q[i-1];
      end
      if (i_data) begin
        win_d[0] = SYM_ONE;
        zcnt_d   = '0;
        par_d    = ~par_q;
      end else if (i_ami) begin
        win_d[0] = SYM_ZERO;
        zcnt_d   = '0;
      end else if (zcnt_q == RUN_MAX) begin
        // (N+1)th zero: insert V. With an even mark count since the last V
        // the first zero of the run becomes B so that consecutive Vs
        // alternate polarity. That zero now sits in the oldest slot.
        win_d[0] = SYM_V;
        zcnt_d   = '0;
        par_d    = 1'b0;
        if (!par_q) begin
          win_d[DEPTH-1] = SYM_B;
        end
      end else begin
        win_d[0] = SYM_ZERO;
        zcnt_d   = zcnt_q + CW'(1);
      end
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      win_q  <= '0;
      zcnt_q <= '0;
      fill_q <= '0;
      par_q  <= 1'b0;
    end else begin
      win_q  <= win_d;
      zcnt_q <= zcnt_d;
      fill_q <= fill_d;
      par_q  <= par_d;
    end
  end

  // Window -> polarity stage boundary: an entry only leaves once the
  // window has been filled since reset.
  assign out_stb  = i_valid && (fill_q == FILL_FULL);
  assign exit_sym = sym_e'(win_q[DEPTH-1]);

  hdbn_polarity u_polarity (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sym  (exit_sym),
    .i_stb  (out_stb),
    .o_code (o_code),
    .o_valid(o_valid)
  );

endmodule

// File: tb/tb_hdbn_encoder.sv
// Self-checking bench for hdbn_encoder. Two instances (N=3 and N=4) share
// the same stimulus; expected symbols come from a reference model that
// applies the HDBn rules to the whole accepted bit list.
module tb_hdbn_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data = 1'b0;
  logic       valid = 1'b0;
  logic       ami = 1'b0;
  logic [1:0] code3, code4;
  logic       vld3, vld4;

  int vectors = 0;
  int miscompares = 0;

  bit         stim_bits[$];
  bit         stim_ami[$];
  logic       stb_seen = 1'b0;
  logic       tr_stb[$];
  logic       tr_v3[$];
  logic       tr_v4[$];
  logic [1:0] tr_c3[$];
  logic [1:0] tr_c4[$];
  logic [1:0] exp3[$];
  logic [1:0] exp4[$];
  logic [1:0] exp_tmp[$];

  hdbn_encoder #(.N(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .i_ami(ami),
    .o_code(code3), .o_valid(vld3)
  );

  hdbn_encoder #(.N(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .i_ami(ami),
    .o_code(code4), .o_valid(vld4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) stb_seen <= valid && !rst;

  always @(negedge clk) begin
    tr_stb.push_back(stb_seen);
    tr_v3.push_back(vld3);
    tr_c3.push_back(code3);
    tr_v4.push_back(vld4);
    tr_c4.push_back(code4);
  end

  // Reference model: classify the full bit list, rewrite the first zero of a
  // substituted run to B by index, then assign polarities in one pass.
  function automatic void build_exp(input int n);
    int t[$];
    int run, marks, last;
    run = 0; marks = 0; last = -1;
    exp_tmp = {};
    for (int k = 0; k < stim_bits.size(); k++) begin
      if (stim_bits[k]) begin
        t.push_back(1); run = 0; marks++;
      end else if (stim_ami[k]) begin
        t.push_back(0); run = 0;
      end else if (run == n) begin
        t.push_back(3); run = 0;
        if (marks % 2 == 0) t[k-n] = 2;
        marks = 0;
      end else begin
        t.push_back(0); run++;
      end
    end
    for (int k = 0; k < t.size(); k++) begin
      if (t[k] == 1 || t[k] == 2) begin
        last = -last;
        exp_tmp.push_back(last > 0 ? 2'b01 : 2'b10);
      end else if (t[k] == 3) begin
        exp_tmp.push_back(last > 0 ? 2'b01 : 2'b10);
      end else begin
        exp_tmp.push_back(2'b00);
      end
    end
  endfunction

  task automatic start_run();
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    stim_bits = {}; stim_ami = {};
    tr_stb = {}; tr_v3 = {}; tr_c3 = {}; tr_v4 = {}; tr_c4 = {};
  endtask

  task automatic drive(input bit b, input bit a, input int gap);
    data = b; ami = a; valid = 1'b1;
    stim_bits.push_back(b);
    stim_ami.push_back(a);
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic end_run();
    repeat (2) @(posedge clk);
    #1;
    build_exp(3); exp3 = exp_tmp;
    build_exp(4); exp4 = exp_tmp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (code3 !== 2'b00 || vld3 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_n3 got code=%b valid=%b exp code=00 valid=0", code3, vld3);
    end
    vectors++;
    if (code4 !== 2'b00 || vld4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_n4 got code=%b valid=%b exp code=00 valid=0", code4, vld4);
    end
    // Strobes while reset is held must be ignored.
    data = 1'b1; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (vld3 !== 1'b0 || vld4 !== 1'b0 || code3 !== 2'b00 || code4 !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got v3=%b c3=%b v4=%b c4=%b exp all zero",
                 i, vld3, code3, vld4, code4);
      end
    end
    valid = 1'b0; data = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] pat, gpat;
    int len, gap;
    bit a, use_gold;
    for (int sc = 0; sc < 5; sc++) begin
      len = 13; gap = 0; a = 1'b0; use_gold = 1'b1;
      case (sc)
        0: begin pat = 16'b0001000011111111; gpat = 16'b0100000001100110; end
        1: begin pat = 16'b0; gpat = 16'b0100000110000010; end
        2: begin pat = 16'b0001000001100000; gpat = 16'b0100000000001001; a = 1'b1; end
        3: begin pat = 16'b1000000000000000; gpat = 16'b0; len = 16; use_gold = 1'b0; end
        default: begin pat = 16'b0001000011111111; gpat = 16'b0100000001100110; gap = 2; end
      endcase
      start_run();
      for (int k = 0; k < len; k++) drive(pat[len-1-k], a, gap);
      end_run();
      for (int d = 0; d < 2; d++) begin
        int depth, ns;
        logic [1:0] prev, c, e;
        logic v, ev;
        depth = d + 4; ns = 0; prev = 2'b00;
        for (int i = 0; i < tr_stb.size(); i++) begin
          v = (d == 0) ? tr_v3[i] : tr_v4[i];
          c = (d == 0) ? tr_c3[i] : tr_c4[i];
          if (tr_stb[i]) ns++;
          ev = tr_stb[i] && (ns > depth);
          vectors++;
          if (v !== ev) begin
            miscompares++;
            $display("FAIL directed%0d_valid n=%0d cyc=%0d got %b exp %b", sc, d + 3, i, v, ev);
          end else begin
            e = v ? ((d == 0) ? exp3[ns-depth-1] : exp4[ns-depth-1]) : prev;
            vectors++;
            if (c !== e) begin
              miscompares++;
              $display("FAIL directed%0d_code n=%0d cyc=%0d got %b exp %b", sc, d + 3, i, c, e);
            end
          end
          prev = c;
        end
      end
      if (use_gold) begin
        logic [1:0] got[$];
        logic [1:0] g, o;
        for (int i = 0; i < tr_v3.size(); i++) if (tr_v3[i]) got.push_back(tr_c3[i]);
        for (int j = 0; j < 8; j++) begin
          g = gpat[15-2*j -: 2];
          o = (j < got.size()) ? got[j] : 2'bxx;
          vectors++;
          if (o !== g) begin
            miscompares++;
            $display("FAIL directed%0d_golden sym=%0d got %b exp %b", sc, j, o, g);
          end
        end
      end
    end
  endtask

  task automatic test_random_hdb();
    int maxrun[2];
    start_run();
    for (int k = 0; k < 200; k++) begin
      drive(($urandom_range(0, 3) == 0), 1'b0,
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    end_run();
    for (int d = 0; d < 2; d++) begin
      int depth, ns, run;
      logic [1:0] prev, c, e;
      logic v, ev;
      depth = d + 4; ns = 0; prev = 2'b00; run = 0; maxrun[d] = 0;
      for (int i = 0; i < tr_stb.size(); i++) begin
        v = (d == 0) ? tr_v3[i] : tr_v4[i];
        c = (d == 0) ? tr_c3[i] : tr_c4[i];
        if (tr_stb[i]) ns++;
        ev = tr_stb[i] && (ns > depth);
        vectors++;
        if (v !== ev) begin
          miscompares++;
          $display("FAIL random_valid n=%0d cyc=%0d got %b exp %b", d + 3, i, v, ev);
        end else begin
          e = v ? ((d == 0) ? exp3[ns-depth-1] : exp4[ns-depth-1]) : prev;
          vectors++;
          if (c !== e) begin
            miscompares++;
            $display("FAIL random_code n=%0d cyc=%0d got %b exp %b", d + 3, i, c, e);
          end
        end
        if (v) begin
          run = (c == 2'b00) ? run + 1 : 0;
          if (run > maxrun[d]) maxrun[d] = run;
        end
        prev = c;
      end
      vectors++;
      if (maxrun[d] > d + 3) begin
        miscompares++;
        $display("FAIL random_zero_run n=%0d got max run %0d exp <= %0d", d + 3, maxrun[d], d + 3);
      end
    end
  endtask

  task automatic test_mixed_mode();
    bit a;
    a = 1'b0;
    start_run();
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 15) == 0) a = ~a;
      drive(($urandom_range(0, 2) == 0), a, ($urandom_range(0, 4) == 0) ? 1 : 0);
    end
    end_run();
    for (int d = 0; d < 2; d++) begin
      int depth, ns;
      logic [1:0] prev, c, e;
      logic v, ev;
      depth = d + 4; ns = 0; prev = 2'b00;
      for (int i = 0; i < tr_stb.size(); i++) begin
        v = (d == 0) ? tr_v3[i] : tr_v4[i];
        c = (d == 0) ? tr_c3[i] : tr_c4[i];
        if (tr_stb[i]) ns++;
        ev = tr_stb[i] && (ns > depth);
        vectors++;
        if (v !== ev) begin
          miscompares++;
          $display("FAIL mixed_valid n=%0d cyc=%0d got %b exp %b", d + 3, i, v, ev);
        end else begin
          e = v ? ((d == 0) ? exp3[ns-depth-1] : exp4[ns-depth-1]) : prev;
          vectors++;
          if (c !== e) begin
            miscompares++;
            $display("FAIL mixed_code n=%0d cyc=%0d got %b exp %b", d + 3, i, c, e);
          end
        end
        prev = c;
      end
    end
  endtask

  task automatic test_mid_reset();
    start_run();
    for (int k = 0; k < 10; k++) drive($urandom_range(0, 1), 1'b0, 0);
    // Asynchronous reset between clock edges, while o_valid is high.
    rst = 1'b1;
    #1;
    vectors++;
    if (vld3 !== 1'b0 || code3 !== 2'b00 || vld4 !== 1'b0 || code4 !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_reset_async got v3=%b c3=%b v4=%b c4=%b exp all zero",
               vld3, code3, vld4, code4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    stim_bits = {}; stim_ami = {};
    tr_stb = {}; tr_v3 = {}; tr_c3 = {}; tr_v4 = {}; tr_c4 = {};
    drive(1'b1, 1'b0, 0);
    for (int k = 0; k < 14; k++) drive($urandom_range(0, 1), 1'b0, 0);
    end_run();
    for (int d = 0; d < 2; d++) begin
      int depth, ns, first;
      logic [1:0] prev, c, e;
      logic v, ev;
      depth = d + 4; ns = 0; prev = 2'b00; first = 1;
      for (int i = 0; i < tr_stb.size(); i++) begin
        v = (d == 0) ? tr_v3[i] : tr_v4[i];
        c = (d == 0) ? tr_c3[i] : tr_c4[i];
        if (tr_stb[i]) ns++;
        ev = tr_stb[i] && (ns > depth);
        vectors++;
        if (v !== ev) begin
          miscompares++;
          $display("FAIL mid_reset_valid n=%0d cyc=%0d got %b exp %b", d + 3, i, v, ev);
        end else begin
          e = v ? ((d == 0) ? exp3[ns-depth-1] : exp4[ns-depth-1]) : prev;
          vectors++;
          if (c !== e) begin
            miscompares++;
            $display("FAIL mid_reset_code n=%0d cyc=%0d got %b exp %b", d + 3, i, c, e);
          end
        end
        if (v && first == 1) begin
          first = 0;
          vectors++;
          if (c !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_reset_first_mark n=%0d got %b exp 01", d + 3, c);
          end
        end
        prev = c;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_hdb();
    test_mixed_mode();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
